// File: rtl/dma_pkg.sv
// Shared definitions for the DMA write-burst controller: FSM encoding, AXI
// constants and the priority-to-burst-length mapping.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned BOUNDARY_4K = 4096;
  localparam logic [1:0]  BRESP_OKAY  = 2'b00;

  // Each priority step halves the burst length, never below one beat.
  function automatic int unsigned beat_limit(input int unsigned max_beats,
                                             input logic [2:0]  pri);
    int unsigned lim;
    lim = max_beats >> pri;
    return (lim == 0) ? 1 : lim;
  endfunction

endpackage

// File: rtl/dma_rr_pri_arb.sv
// Combinational arbiter: lowest priority value wins, ties resolved round-robin
// starting from the channel after the last grant.
module dma_rr_pri_arb #(
  parameter int NUM_CHANNELS = 4
) (
  input  logic [NUM_CHANNELS-1:0]   req,
  input  logic [NUM_CHANNELS*3-1:0] pri,
  input  logic [2:0]                last,
  output logic [NUM_CHANNELS-1:0]   grant
);

  logic [2:0] min_pri;
  logic       found;
  int         idx;

  always_comb begin
    min_pri = 3'd7;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (req[i] && (pri[i*3 +: 3] < min_pri)) min_pri = pri[i*3 +: 3];
    end

    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx = (int'(last) + k) % NUM_CHANNELS;
      if (!found && req[idx] && (pri[idx*3 +: 3] == min_pri)) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_wr_burst_ctrl.sv
// Multi-channel AXI4 write-burst controller: arbitrates channel requests, splits
// each into INCR bursts (priority-scaled length, 4 KB safe) and tracks responses.
module dma_wr_burst_ctrl
  import dma_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int BCNT_WIDTH      = 23,
  parameter int BUS_BYTES       = 8,
  parameter int MAX_BEATS       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  input  logic [NUM_CHANNELS-1:0]        req_valid,
  output logic [NUM_CHANNELS-1:0]        req_ready,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CHANNELS*BCNT_WIDTH-1:0] req_bcnt,
  input  logic [NUM_CHANNELS*3-1:0]      req_pri,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [ADDR_WIDTH-1:0]          cmd_addr,
  output logic [7:0]                     cmd_len,
  output logic [2:0]                     cmd_id,
  input  logic                           bresp_valid,
  input  logic [2:0]                     bresp_id,
  input  logic [1:0]                     bresp_resp,
  output logic                           done_valid,
  output logic [2:0]                     done_ch,
  output logic                           done_err,
  output logic                           busy
);

  localparam int LOG2_BB = $clog2(BUS_BYTES);
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);
  // Burst arithmetic width: wide enough for the byte count and for 4096/limit bytes.
  localparam int CW      = (BCNT_WIDTH > 16) ? BCNT_WIDTH : 16;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  function automatic logic [BCNT_WIDTH-1:0] sat_sub(input logic [BCNT_WIDTH-1:0] a,
                                                    input logic [CW-1:0]         b);
    logic [CW-1:0] ax;
    ax = CW'(a);
    return (b >= ax) ? '0 : BCNT_WIDTH'(ax - b);
  endfunction

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BCNT_WIDTH-1:0] rem_q, rem_d;
  logic [2:0]            pri_q, pri_d;
  logic [2:0]            ch_q, ch_d;
  logic [CW-1:0]         bytes_q, bytes_d;
  logic [2:0]            last_q, last_d;
  logic                  err_q, err_d;
  logic [OW-1:0]         out_q, out_d;

  logic [NUM_CHANNELS-1:0] req_ready_d;
  logic                    cmd_valid_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_d;
  logic [7:0]              cmd_len_d;
  logic [2:0]              cmd_id_d;
  logic                    done_valid_d;
  logic [2:0]              done_ch_d;
  logic                    done_err_d;
  logic                    busy_d;

  logic [NUM_CHANNELS-1:0] grant;
  logic [2:0]              gnt_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [BCNT_WIDTH-1:0]   sel_bcnt;
  logic [2:0]              sel_pri;

  logic [CW-1:0] rem_x, lim_bytes, to4k, calc_bytes, beats;
  logic [7:0]    calc_len;
  logic          issue, resp_cnt;

  dma_rr_pri_arb #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arb (
    .req  (req_valid),
    .pri  (req_pri),
    .last (last_q),
    .grant(grant)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_bcnt = '0;
    sel_pri  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant[i]) begin
        gnt_idx  = 3'(i);
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_bcnt = req_bcnt[i*BCNT_WIDTH +: BCNT_WIDTH];
        sel_pri  = req_pri[i*3 +: 3];
      end
    end
  end

  // Next burst size: smallest of remaining bytes, priority limit and distance to 4 KB.
  always_comb begin
    rem_x      = CW'(rem_q);
    lim_bytes  = CW'(beat_limit(MAX_BEATS, pri_q) * BUS_BYTES);
    to4k       = CW'(BOUNDARY_4K - 32'(addr_q[11:0]));
    calc_bytes = rem_x;
    if (lim_bytes < calc_bytes) calc_bytes = lim_bytes;
    if (to4k < calc_bytes)      calc_bytes = to4k;
    beats      = (calc_bytes + CW'(BUS_BYTES - 1)) >> LOG2_BB;
    calc_len   = 8'(beats - CW'(1));
  end

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    rem_d        = rem_q;
    pri_d        = pri_q;
    ch_d         = ch_q;
    bytes_d      = bytes_q;
    last_d       = last_q;
    req_ready_d  = '0;
    cmd_valid_d  = cmd_valid;
    cmd_addr_d   = cmd_addr;
    cmd_len_d    = cmd_len;
    cmd_id_d     = cmd_id;
    done_valid_d = 1'b0;
    done_ch_d    = done_ch;
    done_err_d   = done_err;

    issue    = cmd_valid & cmd_ready;
    resp_cnt = bresp_valid && (out_q != '0);
    err_d    = err_q | (resp_cnt && ((bresp_resp != BRESP_OKAY) || (bresp_id != ch_q)));
    out_d    = out_q + OW'(issue) - OW'(resp_cnt);

    case (state)
      IDLE: begin
        if (|grant) begin
          req_ready_d = grant;
          addr_d      = sel_addr;
          rem_d       = sel_bcnt;
          pri_d       = sel_pri;
          ch_d        = gnt_idx;
          last_d      = gnt_idx;
          err_d       = 1'b0;
          if (sel_bcnt == '0) begin
            state_d      = DONE;
            done_valid_d = 1'b1;
            done_ch_d    = gnt_idx;
            done_err_d   = 1'b0;
          end else if (sel_addr[LOG2_BB-1:0] != '0) begin
            state_d      = DONE;
            done_valid_d = 1'b1;
            done_ch_d    = gnt_idx;
            done_err_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        bytes_d     = calc_bytes;
        cmd_addr_d  = addr_q;
        cmd_len_d   = calc_len;
        cmd_id_d    = ch_q;
        cmd_valid_d = (out_d < MAX_OUT);
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (issue) begin
          cmd_valid_d = 1'b0;
          addr_d      = addr_q + ADDR_WIDTH'(bytes_q);
          rem_d       = sat_sub(rem_q, bytes_q);
          state_d     = (rem_d == '0) ? DRAIN : CALC;
        end else if (!cmd_valid) begin
          // Held back by the outstanding limit; release as soon as a response frees a slot.
          cmd_valid_d = (out_d < MAX_OUT);
        end
      end
      DRAIN: begin
        if (out_q == '0) begin
          state_d      = DONE;
          done_valid_d = 1'b1;
          done_ch_d    = ch_q;
          done_err_d   = err_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (out_d != '0);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      last_q     <= 3'(NUM_CHANNELS - 1);
      err_q      <= 1'b0;
      out_q      <= '0;
      req_ready  <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      cmd_id     <= '0;
      done_valid <= 1'b0;
      done_ch    <= '0;
      done_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      last_q     <= last_d;
      err_q      <= err_d;
      out_q      <= out_d;
      req_ready  <= req_ready_d;
      cmd_valid  <= cmd_valid_d;
      cmd_addr   <= cmd_addr_d;
      cmd_len    <= cmd_len_d;
      cmd_id     <= cmd_id_d;
      done_valid <= done_valid_d;
      done_ch    <= done_ch_d;
      done_err   <= done_err_d;
      busy       <= busy_d;
    end
  end

  // Request context is only consumed after a fresh grant, so it needs no reset.
  always_ff @(posedge CLOCK) begin
    addr_q  <= addr_d;
    rem_q   <= rem_d;
    pri_q   <= pri_d;
    ch_q    <= ch_d;
    bytes_q <= bytes_d;
  end

endmodule
